// File: rtl/mult_div_pkg.sv
// Shared definitions for the multiply/divide engine and the control unit that drives it.
package mult_div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MULT_RUN = 2'd1,
    ST_DIV_RUN  = 2'd2,
    ST_FINISH   = 2'd3
  } md_state_e;

  localparam int MD_ITERATIONS = 32;

  localparam logic [5:0] FUNCT_MULT = 6'h18;
  localparam logic [5:0] FUNCT_DIV  = 6'h1A;

endpackage

// File: rtl/mult_div_unit.sv
// Multicycle signed Booth multiplier / restoring divider with Hi/Lo result registers.
// Handshake: a start is taken on any edge where the engine is Idle or in Finish; Done pulses for one cycle when Hi/Lo are fresh.
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             MultStart,
  input  logic             DivStart,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero
);

  localparam int         SR_W = 2 * WIDTH + 1;
  localparam logic [4:0] LAST_ITER = 5'(MD_ITERATIONS - 1);

  md_state_e        r_state;
  logic [SR_W-1:0]  r_sr;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [4:0]       r_count;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dz;

  logic             w_is_div;
  logic             w_use;
  logic             w_sub;
  logic [WIDTH:0]   w_op_a;
  logic [WIDTH:0]   w_op_b;
  logic [WIDTH:0]   w_sum;
  logic [SR_W-1:0]  w_sr_next;
  logic [WIDTH-1:0] w_upper;
  logic [WIDTH-1:0] w_lower;
  logic [WIDTH-1:0] w_res_hi;
  logic [WIDTH-1:0] w_res_lo;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic             w_accept;

  assign w_is_div = (r_state == ST_DIV_RUN);
  assign w_abs_a  = A[WIDTH-1] ? -A : A;
  assign w_abs_b  = B[WIDTH-1] ? -B : B;
  assign w_accept = (r_state == ST_IDLE) || (r_state == ST_FINISH);

  // Multiply keeps {acc, multiplier, guard}; divide keeps {remainder, quotient, unused}.
  always_comb begin
    w_use  = 1'b0;
    w_sub  = 1'b0;
    w_op_a = '0;
    w_op_b = '0;
    if (w_is_div) begin
      w_op_a = r_sr[SR_W-1:WIDTH];
      w_op_b = {1'b0, r_m};
      w_use  = 1'b1;
      w_sub  = 1'b1;
    end else begin
      w_op_a = {r_sr[SR_W-1], r_sr[SR_W-1:WIDTH+1]};
      w_op_b = {r_m[WIDTH-1], r_m};
      case (r_sr[1:0])
        2'b01:   w_use = 1'b1;
        2'b10: begin
          w_use = 1'b1;
          w_sub = 1'b1;
        end
        default: w_use = 1'b0;
      endcase
    end
  end

  assign w_sum = !w_use ? w_op_a : (w_sub ? (w_op_a - w_op_b) : (w_op_a + w_op_b));

  // A negative trial difference restores the shifted remainder and shifts in a 0 quotient bit.
  always_comb begin
    w_sr_next = '0;
    if (w_is_div) begin
      w_sr_next = {(w_sum[WIDTH] ? w_op_a[WIDTH-1:0] : w_sum[WIDTH-1:0]),
                   r_sr[WIDTH-1:1], ~w_sum[WIDTH], 1'b0};
    end else begin
      w_sr_next = {w_sum, r_sr[WIDTH:1]};
    end
  end

  assign w_upper  = w_sr_next[SR_W-1:WIDTH+1];
  assign w_lower  = w_sr_next[WIDTH:1];
  assign w_res_hi = (w_is_div && r_neg_r) ? -w_upper : w_upper;
  assign w_res_lo = (w_is_div && r_neg_q) ? -w_lower : w_lower;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_sr    <= '0;
      r_m     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_count <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
    end else if (w_accept) begin
      r_count <= '0;
      r_dz    <= 1'b0;
      if (MultStart) begin
        r_state <= ST_MULT_RUN;
        r_sr    <= {{WIDTH{1'b0}}, B, 1'b0};
        r_m     <= A;
      end else if (DivStart && (B == '0)) begin
        r_state <= ST_FINISH;
        r_dz    <= 1'b1;
      end else if (DivStart) begin
        r_state <= ST_DIV_RUN;
        r_sr    <= {{WIDTH{1'b0}}, w_abs_a, 1'b0};
        r_m     <= w_abs_b;
        r_neg_q <= A[WIDTH-1] ^ B[WIDTH-1];
        r_neg_r <= A[WIDTH-1];
      end else begin
        r_state <= ST_IDLE;
      end
    end else begin
      r_sr <= w_sr_next;
      if (r_count == LAST_ITER) begin
        r_state <= ST_FINISH;
        r_count <= '0;
        r_hi    <= w_res_hi;
        r_lo    <= w_res_lo;
      end else begin
        r_count <= r_count + 5'd1;
      end
    end
  end

  assign Hi      = r_hi;
  assign Lo      = r_lo;
  assign Busy    = (r_state != ST_IDLE);
  assign Done    = (r_state == ST_FINISH);
  assign DivZero = (r_state == ST_FINISH) && r_dz;

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized and directed bench for mult_div_unit with a queue-based scoreboard.
module tb_mult_div_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        MultStart;
  logic        DivStart;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] Hi;
  logic [31:0] Lo;
  logic        Busy;
  logic        Done;
  logic        DivZero;

  mult_div_unit #(.WIDTH(32)) dut (
    .clock    (clock),
    .reset    (reset),
    .MultStart(MultStart),
    .DivStart (DivStart),
    .A        (A),
    .B        (B),
    .Hi       (Hi),
    .Lo       (Lo),
    .Busy     (Busy),
    .Done     (Done),
    .DivZero  (DivZero)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [64:0] exp_q[$];
  int          cyc_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;
  logic [64:0] mon_e;
  int          mon_c;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference: plain 64-bit signed arithmetic; SV / and % truncate toward zero.
  function automatic logic [63:0] ref_result(input logic mul, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, p, q, m;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (mul) begin
      p = sa * sb;
      return p[63:0];
    end
    q = sa / sb;
    m = sa % sb;
    return {m[31:0], q[31:0]};
  endfunction

  task automatic push_exp(input logic mul, input logic dv, input logic [31:0] a,
                          input logic [31:0] b, output int lat);
    logic dz;
    dz  = 1'b0;
    lat = 33;
    if (mul) begin
      {model_hi, model_lo} = ref_result(1'b1, a, b);
    end else if (dv && b == 32'd0) begin
      dz  = 1'b1;
      lat = 1;
    end else begin
      {model_hi, model_lo} = ref_result(1'b0, a, b);
    end
    exp_q.push_back({dz, model_hi, model_lo});
    cyc_q.push_back(cyc + lat);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    if (!reset) begin
      if (Done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          mon_c = cyc_q.pop_front();
          check("hi", 64'(Hi), 64'(mon_e[63:32]));
          check("lo", 64'(Lo), 64'(mon_e[31:0]));
          check("divzero", 64'(DivZero), 64'(mon_e[64]));
          check("done_cycle", 64'(cyc), 64'(mon_c));
        end
      end else if (DivZero) begin
        check("divzero_without_done", 64'd1, 64'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_op(input logic mul, input logic dv, input logic [31:0] a,
                        input logic [31:0] b, input int mid_div);
    int lat;
    int n;
    A = a;
    B = b;
    MultStart = mul;
    DivStart  = dv;
    push_exp(mul, dv, a, b, lat);
    @(negedge clock);
    MultStart = 1'b0;
    DivStart  = 1'b0;
    A = $urandom;
    B = $urandom;
    n = 0;
    while (Busy && n < 100) begin
      n++;
      DivStart = (mid_div != 0) && (n == mid_div);
      @(negedge clock);
    end
    DivStart = 1'b0;
    check("busy_cycles", 64'(n), 64'(lat));
  endtask

  task automatic run_back_to_back(input logic [31:0] a1, input logic [31:0] b1,
                                  input logic [31:0] a2, input logic [31:0] b2);
    int lat;
    int n;
    A = a1;
    B = b1;
    MultStart = 1'b1;
    push_exp(1'b1, 1'b0, a1, b1, lat);
    repeat (33) @(negedge clock);
    A = a2;
    B = b2;
    push_exp(1'b1, 1'b0, a2, b2, lat);
    @(negedge clock);
    MultStart = 1'b0;
    A = $urandom;
    B = $urandom;
    n = 0;
    while (Busy && n < 100) begin
      n++;
      @(negedge clock);
    end
    check("b2b_second_busy", 64'(n), 64'd33);
  endtask

  task automatic reset_mid_op(input logic [31:0] a, input logic [31:0] b);
    int lat;
    A = a;
    B = b;
    MultStart = 1'b1;
    push_exp(1'b1, 1'b0, a, b, lat);
    @(negedge clock);
    MultStart = 1'b0;
    repeat (9) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("abort_busy", 64'(Busy), 64'd0);
    check("abort_hi", 64'(Hi), 64'd0);
    check("abort_lo", 64'(Lo), 64'd0);
    check("abort_done", 64'(Done), 64'd0);
    void'(exp_q.pop_back());
    void'(cyc_q.pop_back());
    model_hi = '0;
    model_lo = '0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'(($urandom_range(0, 40)));
      3:       return -32'($urandom_range(1, 40));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    int          sel;
    reset     = 1'b1;
    MultStart = 1'b0;
    DivStart  = 1'b0;
    A         = '0;
    B         = '0;
    repeat (3) @(negedge clock);
    check("reset_hi", 64'(Hi), 64'd0);
    check("reset_lo", 64'(Lo), 64'd0);
    check("reset_busy", 64'(Busy), 64'd0);
    check("reset_done", 64'(Done), 64'd0);
    check("reset_divzero", 64'(DivZero), 64'd0);
    reset = 1'b0;
    @(negedge clock);

    run_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 0);
    check("mult_7x-3_hi_const", 64'(model_hi), 64'h0000_0000_FFFF_FFFF);
    run_op(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 0);
    run_op(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(1'b0, 1'b1, -32'd7, 32'd2, 0);
    run_op(1'b0, 1'b1, 32'd7, -32'd2, 0);
    run_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(1'b1, 1'b0, 32'h0001_2345, 32'hFFFF_6789, 0);
    run_op(1'b0, 1'b1, 32'd5, 32'd0, 0);
    run_op(1'b1, 1'b1, 32'd1234, 32'd5678, 0);
    run_op(1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0BAD_F00D, 10);
    run_back_to_back(32'hFFFF_0001, 32'h0000_FFFF, -32'd100, 32'd37);
    reset_mid_op(32'h1234_5678, 32'h9ABC_DEF0);
    run_op(1'b1, 1'b0, 32'd3, 32'd11, 0);

    for (int i = 0; i < 24; i++) begin
      sel = $urandom_range(0, 3);
      ra  = pick_operand();
      rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : pick_operand();
      run_op((sel == 0) || (sel == 3), (sel != 0), ra, rb, 0);
    end

    repeat (5) @(negedge clock);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
